ex_stage: RTL
=============

# ex_stage

Execute stage of the 8-bit IF → ID → EX pipeline. It consumes the opcode and operands held in the ID/EX pipeline register and computes single-cycle ALU operations. It also runs a multi-cycle 8×8 shift-add multiplier, and drives the stall that freezes the ID/EX register while the multiplier is busy. All results and flags are registered, so its outputs form the EX/WB boundary.

## Interface
- No parameters; widths fixed at 4-bit opcode, 8-bit data.
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- opcode_in  input  4  opcode from ID/EX register
- A_in  input  8  operand A from ID/EX register
- B_in  input  8  operand B from ID/EX register
- stall_out  output  1  combinational; holds ID/EX register (and upstream) when high
- result_out  output  8  registered result (MUL: low byte of product)
- result_hi_out  output  8  registered MUL high byte; 0 for all other ops
- zero_out  output  1  registered: result_out == 0
- carry_out  output  1  registered carry/borrow/shift-out flag
- valid_out  output  1  registered: result_out/flags carry a completed instruction this cycle
- illegal_out  output  1  registered one-cycle pulse for an undefined opcode

## Operation
- Opcode map:
  - 0 NOP
  - 1 ADD
  - 2 SUB (A−B)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT A
  - 7 SHL A by 1
  - 8 MUL
  - 9 SHR A by 1
  - A–F illegal
- Opcode 0 is the ID/EX reset value, so a reset pipeline issues NOPs.
- Carry:
  - ADD: bit 8 of the 9-bit sum.
  - SUB: borrow (A < B).
  - SHL: A[7]. SHR: A[0].
  - MUL: result_hi != 0.
  - AND/OR/XOR/NOT: 0.
- Arithmetic is modulo 256 on result_out.
- Completed op (any legal non-NOP):
  - result_out, result_hi_out, zero_out and carry_out update.
  - valid_out=1 for one cycle.
- NOP:
  - valid_out=0, illegal_out=0.
  - result and flags hold their previous values.
- Illegal opcode:
  - illegal_out=1 and valid_out=0 for one cycle.
  - result and flags hold.
- FSM states IDLE, MUL_BUSY; 3-bit counter cnt.
- IDLE, opcode_in≠8: single-cycle op evaluated; outputs registered at the next edge; stays IDLE.
- IDLE, opcode_in=8:
  - Latch A_in/B_in into a multiplicand/multiplier/accumulator.
  - cnt←0, go to MUL_BUSY.
  - stall_out=1 this cycle; valid_out=0 at the next edge.
- MUL_BUSY:
  - One shift-add step per cycle; cnt increments.
  - stall_out=1 while cnt<7.
  - At cnt=7 the final step completes and stall_out=0. At that edge:
    - the 16-bit product is registered with valid_out=1;
    - the state returns to IDLE;
    - ID/EX loads the next instruction.
- Inputs are ignored in MUL_BUSY. The MUL opcode held by the stall must not restart the multiplier.
- stall_out depends only on state, cnt, opcode_in and rst. It has no path from A_in/B_in.

## Timing
- Single-cycle ops: opcode present in cycle N → outputs valid in cycle N+1; throughput 1/cycle.
- MUL, opcode first seen in cycle N:
  - stall_out high in cycles N..N+7 (8 cycles).
  - Result, with valid_out=1, in cycle N+9.
  - valid_out=0 in cycles N+1..N+8.
- An instruction following a MUL is presented in cycle N+9. Its result appears in cycle N+10.
- Back-to-back MULs: the second MUL is seen in IDLE at cycle N+9 and starts immediately.
- Reset:
  - While rst=1: stall_out=0. The next edge sets:
    - state IDLE, cnt 0;
    - result_out, result_hi_out 0;
    - zero_out, carry_out, valid_out, illegal_out 0.
  - rst during MUL_BUSY abandons the multiply. No valid_out is produced for it.
- valid_out and illegal_out are never high together.

## Configuration
- EX_MUL_EN defined: MUL and FSM behave as above.
- EX_MUL_EN undefined:
  - No multiplier or FSM is built.
  - Opcode 8 is illegal.
  - stall_out is tied to 0; result_hi_out is tied to 0.
  - All other ops are unchanged.

## Test plan
- ADD A=0xF0, B=0x20 → next cycle: result_out=0x10, carry_out=1, zero_out=0, valid_out=1, stall_out never high.
- SUB A=0x05, B=0x05 then SUB A=0x03, B=0x04 → results 0x00 (zero=1, carry=0), then 0xFF (zero=0, carry=1) on consecutive cycles.
- MUL A=0xFF, B=0xFF, held by stall → stall_out high exactly 8 cycles; in cycle N+9 result_hi_out=0xFE, result_out=0x01, carry=1, valid_out=1 for one cycle only.
- MUL A=0x0F, B=0x11 followed by ADD A=0x01, B=0x01 → product 0x00FF (carry=0); ADD result 0x02 exactly one cycle later; no restart of the MUL.
- rst pulsed at cnt=3 of a MUL → all outputs 0, stall_out 0, no valid_out for that MUL; a subsequent XOR 0xAA^0x55 → 0xFF.
- Opcode 0xC, then NOP → illegal_out one-cycle pulse, valid_out 0, result/flags unchanged. Build without EX_MUL_EN: opcode 8 → illegal_out=1, stall_out=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the 8-bit IF/ID/EX pipeline: registered single-cycle ALU plus an optional
// 8-cycle shift-add multiplier with ID/EX stall, enabled by defining EX_MUL_EN.
module ex_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode_in,
  input  logic [7:0] A_in,
  input  logic [7:0] B_in,
  output logic       stall_out,
  output logic [7:0] result_out,
  output logic [7:0] result_hi_out,
  output logic       zero_out,
  output logic       carry_out,
  output logic       valid_out,
  output logic       illegal_out
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;

  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_legal;
  logic       alu_ok;

  // alu_legal covers every defined opcode; alu_ok marks the ones that retire in one cycle.
  always_comb begin
    alu_res   = 8'h00;
    alu_c     = 1'b0;
    alu_legal = 1'b1;
    case (opcode_in)
      OP_NOP: alu_res = 8'h00;
      OP_ADD: {alu_c, alu_res} = {1'b0, A_in} + {1'b0, B_in};
      OP_SUB: begin
        alu_res = A_in - B_in;
        alu_c   = (A_in < B_in);
      end
      OP_AND: alu_res = A_in & B_in;
      OP_OR:  alu_res = A_in | B_in;
      OP_XOR: alu_res = A_in ^ B_in;
      OP_NOT: alu_res = ~A_in;
      OP_SHL: begin
        alu_res = {A_in[6:0], 1'b0};
        alu_c   = A_in[7];
      end
      OP_SHR: begin
        alu_res = {1'b0, A_in[7:1]};
        alu_c   = A_in[0];
      end
`ifdef EX_MUL_EN
      OP_MUL: alu_res = 8'h00;
`endif
      default: alu_legal = 1'b0;
    endcase
  end

  assign alu_ok = alu_legal && (opcode_in != OP_NOP) && (opcode_in != OP_MUL);

`ifdef EX_MUL_EN
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  logic [0:0]  state;
  logic [2:0]  cnt;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [15:0] acc;
  logic [15:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : 16'h0000);

  // Low on the final step so ID/EX loads the next instruction on the same edge the product lands.
  assign stall_out = !rst && (((state == ST_IDLE) && (opcode_in == OP_MUL)) ||
                              ((state == ST_MUL_BUSY) && (cnt != 3'd7)));
`else
  assign stall_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result_out    <= 8'h00;
      result_hi_out <= 8'h00;
      zero_out      <= 1'b0;
      carry_out     <= 1'b0;
      valid_out     <= 1'b0;
      illegal_out   <= 1'b0;
`ifdef EX_MUL_EN
      state  <= ST_IDLE;
      cnt    <= 3'd0;
      mcand  <= 16'h0000;
      mplier <= 8'h00;
      acc    <= 16'h0000;
`endif
    end
`ifdef EX_MUL_EN
    else if (state == ST_MUL_BUSY) begin
      // Inputs are ignored here; the held MUL opcode cannot restart the multiplier.
      acc         <= acc_next;
      mcand       <= {mcand[14:0], 1'b0};
      mplier      <= {1'b0, mplier[7:1]};
      cnt         <= cnt + 3'd1;
      valid_out   <= 1'b0;
      illegal_out <= 1'b0;
      if (cnt == 3'd7) begin
        result_out    <= acc_next[7:0];
        result_hi_out <= acc_next[15:8];
        zero_out      <= (acc_next[7:0] == 8'h00);
        carry_out     <= (acc_next[15:8] != 8'h00);
        valid_out     <= 1'b1;
        state         <= ST_IDLE;
        cnt           <= 3'd0;
      end
    end
    else if (opcode_in == OP_MUL) begin
      mcand       <= {8'h00, A_in};
      mplier      <= B_in;
      acc         <= 16'h0000;
      cnt         <= 3'd0;
      state       <= ST_MUL_BUSY;
      valid_out   <= 1'b0;
      illegal_out <= 1'b0;
    end
`endif
    else if (alu_ok) begin
      result_out    <= alu_res;
      result_hi_out <= 8'h00;
      zero_out      <= (alu_res == 8'h00);
      carry_out     <= alu_c;
      valid_out     <= 1'b1;
      illegal_out   <= 1'b0;
    end
    else begin
      valid_out   <= 1'b0;
      illegal_out <= !alu_legal;
    end
  end

endmodule
